// File: rtl/can_bit_timing.sv
// CAN bit timing: divides clk into time quanta and sequences SYNC/TSEG1/TSEG2, emitting
// tq, sample and bit-start strobes with hard sync and SJW-limited resynchronisation.
module can_bit_timing #(
    parameter int unsigned BRP_W   = 16,
    parameter int unsigned TSEG1_W = 4,
    parameter int unsigned TSEG2_W = 3,
    parameter int unsigned SJW_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               hard_sync_en,
    input  logic               rx,
    output logic               tq_tick,
    output logic               tx_pulse,
    output logic               sample_pulse,
    output logic               sampled_bit,
    output logic [1:0]         seg
);

    // Segment counters must hold the longest TSEG plus the largest SJW extension.
    localparam int unsigned SEG_W = (TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W;
    localparam int unsigned KW    = SEG_W + SJW_W + 1;
    localparam int unsigned CW    = BRP_W + 1;

    typedef enum logic [1:0] {
        SegSync  = 2'd0,
        SegTseg1 = 2'd1,
        SegTseg2 = 2'd2
    } seg_e;

    seg_e             seg_q;
    logic [BRP_W-1:0] cnt_q;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    ext_q;
    logic [KW-1:0]    shr_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    logic             edge_used_q;

    logic             tick;
    logic             edge_det;
    logic             resync;
    logic             early_restart;
    logic [KW-1:0]    sjw_tq;
    logic [KW-1:0]    ext_late;
    logic [KW-1:0]    e_early;
    logic [KW-1:0]    ext_d;
    logic [KW-1:0]    shr_d;
    logic [KW-1:0]    l1_last;
    logic [KW-1:0]    l2_last;

    always_comb begin
        tick          = ({1'b0, cnt_q} + CW'(1)) >= {1'b0, brp};
        edge_det      = ~rx_s_q & rx_prev_q & sampled_bit & ~edge_used_q;
        resync        = edge_det & ~hard_sync_en;
        sjw_tq        = KW'(sjw) + KW'(1);
        ext_late      = k_q + KW'(1);
        e_early       = KW'(tseg2) + KW'(1) - k_q;
        ext_d         = ext_q;
        shr_d         = shr_q;
        early_restart = 1'b0;
        if (resync && seg_q == SegTseg1) begin
            ext_d = (ext_late < sjw_tq) ? ext_late : sjw_tq;
        end
        if (resync && seg_q == SegTseg2) begin
            if (e_early <= sjw_tq) begin
                early_restart = 1'b1;
            end else begin
                shr_d = sjw_tq;
            end
        end
        // New ext/shr apply to the tick that detected the edge.
        l1_last = KW'(tseg1) + ext_d;
        l2_last = KW'(tseg2) - shr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            seg_q        <= SegSync;
            k_q          <= '0;
            ext_q        <= '0;
            shr_q        <= '0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            edge_used_q  <= 1'b0;
            tq_tick      <= 1'b0;
            tx_pulse     <= 1'b0;
            sample_pulse <= 1'b0;
            sampled_bit  <= 1'b1;
        end else if (!enable) begin
            cnt_q        <= '0;
            seg_q        <= SegSync;
            k_q          <= '0;
            ext_q        <= '0;
            shr_q        <= '0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            edge_used_q  <= 1'b0;
            tq_tick      <= 1'b0;
            tx_pulse     <= 1'b0;
            sample_pulse <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            tq_tick      <= tick;
            tx_pulse     <= 1'b0;
            sample_pulse <= 1'b0;
            cnt_q        <= tick ? '0 : cnt_q + BRP_W'(1);
            if (tick) begin
                rx_prev_q <= rx_s_q;
                if (edge_det) begin
                    edge_used_q <= 1'b1;
                end
                // The ending tq becomes SYNC of a new bit.
                if ((edge_det && hard_sync_en) || early_restart) begin
                    seg_q    <= SegTseg1;
                    k_q      <= '0;
                    ext_q    <= '0;
                    shr_q    <= '0;
                    tx_pulse <= 1'b1;
                end else begin
                    case (seg_q)
                        SegSync: begin
                            seg_q <= SegTseg1;
                            k_q   <= '0;
                        end
                        SegTseg1: begin
                            ext_q <= ext_d;
                            if (k_q == l1_last) begin
                                sample_pulse <= 1'b1;
                                sampled_bit  <= rx_s_q;
                                edge_used_q  <= 1'b0;
                                seg_q        <= SegTseg2;
                                k_q          <= '0;
                            end else begin
                                k_q <= k_q + KW'(1);
                            end
                        end
                        SegTseg2: begin
                            shr_q <= shr_d;
                            if (k_q == l2_last) begin
                                seg_q    <= SegSync;
                                k_q      <= '0;
                                ext_q    <= '0;
                                shr_q    <= '0;
                                tx_pulse <= 1'b1;
                            end else begin
                                k_q <= k_q + KW'(1);
                            end
                        end
                        default: begin
                            seg_q <= SegSync;
                            k_q   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign seg = seg_q;

endmodule
